fetch_unit: RTL and testbench

- IF stage of the 31-instruction MIPS pipeline.
- Owns the architectural fetch PC, issues one-outstanding requests to instruction memory, and drives the IF/ID pipeline register.
- Consumes the ID-stage branch resolution (is_branch/branch_pc) and supplies pc_out, which the branch unit uses as delay_slot_pc.
- Implements the single MIPS delay slot: a taken branch redirects the fetch after the delay-slot instruction.

---
 rtl/mips_pkg.sv | 12 +
 rtl/fetch_hold_buf.sv | 34 +++
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and FSM encoding for the MIPS fetch stage
// Contents: reset/exception vector defaults, NOP word, fetch FSM state type.
package mips_pkg;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;
    localparam logic [31:0] NOP            = 32'h0000_0000;
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: 1-entry {instr, pc} skid register for a fetch that ID cannot take yet
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   load               capture in_instr/in_pc and set valid
//   unload             clear valid (entry handed to ID)
//   in_instr, in_pc    word and address to capture
//   valid, instr, pc   buffered entry
module fetch_hold_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= NOP;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS IF stage - fetch PC, one-outstanding imem requests, IF/ID register, delay-slot redirect
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   imem_req, imem_addr        fetch request and word address (imem_addr == pc_out)
//   imem_ack, imem_rdata       one-cycle response pulse and fetched word
//   stall                      ID cannot accept a new instruction
//   is_branch, branch_pc       ID-stage redirect and its target
//   pc_out                     PC of the instruction in IF (delay-slot PC for the branch unit)
//   id_valid, id_instr, id_pc  IF/ID register
//   fetch_addr_err             (FETCH_ADDR_CHECK_EN only) pulses when a misaligned redirect
//                              was replaced by EXC_VECTOR and applied to pc_out
// Build option: define FETCH_ADDR_CHECK_EN to replace misaligned redirect targets by EXC_VECTOR.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
`ifdef FETCH_ADDR_CHECK_EN
    , parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        is_branch,
    input  logic [31:0] branch_pc,
    output logic [31:0] pc_out,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_ADDR_CHECK_EN
    , output logic      fetch_addr_err
`endif
);
    fetch_state_e state, state_nx;
    logic        ack_take, hold_load, fetch_deliver, hold_deliver, deliver;
    logic        accept, br;
    logic        redir_pending;
    logic [31:0] redir_pc, br_target, next_pc;
    logic        hold_valid;
    logic [31:0] hold_instr, hold_pc, deliver_instr, deliver_pc;

    // Responses are only honoured in FETCH, so a late ack around reset is dropped.
    assign ack_take      = (state == FETCH) && imem_ack;
    assign accept        = id_valid && !stall;
    assign hold_load     = ack_take && stall && id_valid;
    assign fetch_deliver = ack_take && !hold_load;
    assign hold_deliver  = (state == HOLD) && hold_valid && !stall;
    assign deliver       = fetch_deliver || hold_deliver;
    // The instruction still in IF (pc_out) is the delay slot of an accepted branch.
    assign br            = accept && is_branch;
    assign deliver_instr = hold_deliver ? hold_instr : imem_rdata;
    assign deliver_pc    = hold_deliver ? hold_pc : pc_out;
    assign imem_addr     = pc_out;

`ifdef FETCH_ADDR_CHECK_EN
    logic br_bad, redir_err;
    assign br_bad    = |branch_pc[1:0];
    assign br_target = br_bad ? EXC_VECTOR : branch_pc;
`else
    assign br_target = branch_pc;
`endif

    // Same-cycle redirect beats a recorded one; otherwise sequential with natural 32-bit wrap.
    assign next_pc = br ? br_target : redir_pending ? redir_pc : pc_out + 32'd4;

    fetch_hold_buf u_hold (
        .clk      (clk),
        .reset    (reset),
        .load     (hold_load),
        .unload   (hold_deliver),
        .in_instr (imem_rdata),
        .in_pc    (pc_out),
        .valid    (hold_valid),
        .instr    (hold_instr),
        .pc       (hold_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        case (state)
            BOOT:    state_nx = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                state_nx = hold_load ? HOLD : FETCH;
            end
            HOLD:    state_nx = stall ? HOLD : FETCH;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out        <= RESET_PC;
            id_valid      <= 1'b0;
            id_instr      <= NOP;
            id_pc         <= '0;
            redir_pending <= 1'b0;
            redir_pc      <= '0;
        end else begin
            if (deliver) begin
                pc_out   <= next_pc;
                id_valid <= 1'b1;
                id_instr <= deliver_instr;
                id_pc    <= deliver_pc;
            end else if (accept) begin
                id_valid <= 1'b0;
            end
            // Delivering the delay slot consumes any redirect; a branch without it is recorded.
            if (deliver) begin
                redir_pending <= 1'b0;
            end else if (br) begin
                redir_pending <= 1'b1;
                redir_pc      <= br_target;
            end
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_err      <= 1'b0;
            fetch_addr_err <= 1'b0;
        end else begin
            if (br && !deliver) redir_err <= br_bad;
            fetch_addr_err <= deliver && (br ? br_bad : (redir_pending && redir_err));
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, stall, is_branch, id_valid;
    logic [31:0] imem_addr, imem_rdata, branch_pc, pc_out, id_instr, id_pc;
`ifdef FETCH_ADDR_CHECK_EN
    logic        fetch_addr_err;
    localparam logic [31:0] P = 32'h0040_0004;
`else
    localparam logic [31:0] P = 32'h0040_0102;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .is_branch  (is_branch),
        .branch_pc  (branch_pc),
        .pc_out     (pc_out),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
`ifdef FETCH_ADDR_CHECK_EN
        , .fetch_addr_err (fetch_addr_err)
`endif
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] bpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_instr;
        logic [31:0] e_idpc;
        logic        e_err;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] iw(input int n);
        return 32'hA000_0000 + 32'(n);
    endfunction

    task automatic add(input logic a, input logic [31:0] rd, input logic s, input logic b,
                       input logic [31:0] bp, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                       input logic ee);
        vec_t v;
        v.ack = a; v.rdata = rd; v.stall = s; v.br = b; v.bpc = bp;
        v.e_req = er; v.e_addr = ea; v.e_idv = ev; v.e_instr = ei; v.e_idpc = ep; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'd0);
        chk({tag, "_pc"},    pc_out,        32'h0040_0000);
        chk({tag, "_addr"},  imem_addr,     32'h0040_0000);
        chk({tag, "_idv"},   32'(id_valid), 32'd0);
        chk({tag, "_instr"}, id_instr,      32'd0);
        chk({tag, "_idpc"},  id_pc,         32'd0);
    endtask

    initial begin
        //    ack rdata      stl br bpc             req addr            idv instr    idpc            err
        add(0, 0,        0, 0, 0,             0, 32'h0040_0000, 0, 0,       0,             0);
        add(1, iw(0),    0, 0, 0,             1, 32'h0040_0000, 0, 0,       0,             0);
        add(1, iw(1),    0, 0, 0,             1, 32'h0040_0004, 1, iw(0),   32'h0040_0000, 0);
        add(1, iw(2),    1, 0, 0,             1, 32'h0040_0008, 1, iw(1),   32'h0040_0004, 0);
        add(0, 0,        1, 1, 32'h0060_0000, 0, 32'h0040_0008, 1, iw(1),   32'h0040_0004, 0);
        add(0, 0,        1, 0, 0,             0, 32'h0040_0008, 1, iw(1),   32'h0040_0004, 0);
        add(0, 0,        0, 0, 0,             0, 32'h0040_0008, 1, iw(1),   32'h0040_0004, 0);
        add(1, iw(3),    0, 0, 0,             1, 32'h0040_000C, 1, iw(2),   32'h0040_0008, 0);
        add(1, iw(4),    0, 0, 0,             1, 32'h0040_0010, 1, iw(3),   32'h0040_000C, 0);
        add(0, 0,        0, 1, 32'h0040_0100, 1, 32'h0040_0014, 1, iw(4),   32'h0040_0010, 0);
        add(0, 0,        0, 1, 32'h0050_0000, 1, 32'h0040_0014, 0, iw(4),   32'h0040_0010, 0);
        add(1, iw(5),    0, 0, 0,             1, 32'h0040_0014, 0, iw(4),   32'h0040_0010, 0);
        add(1, iw(6),    0, 1, 32'h0040_0200, 1, 32'h0040_0100, 1, iw(5),   32'h0040_0014, 0);
        add(0, 0,        0, 0, 0,             1, 32'h0040_0200, 1, iw(6),   32'h0040_0100, 0);
        add(1, iw(7),    0, 0, 0,             1, 32'h0040_0200, 0, iw(6),   32'h0040_0100, 0);
        add(1, iw(8),    0, 1, 32'h0040_0102, 1, 32'h0040_0204, 1, iw(7),   32'h0040_0200, 0);
        add(0, 0,        0, 0, 0,             1, P,             1, iw(8),   32'h0040_0204, 1);
        add(1, iw(9),    1, 0, 0,             1, P,             0, iw(8),   32'h0040_0204, 0);
        add(0, 0,        1, 1, 32'hDEAD_0000, 1, P + 32'd4,     1, iw(9),   P,             0);
        add(1, iw(10),   0, 1, 32'hFFFF_FFFC, 1, P + 32'd4,     1, iw(9),   P,             0);
        add(1, iw(11),   0, 0, 0,             1, 32'hFFFF_FFFC, 1, iw(10),  P + 32'd4,     0);
        add(0, 0,        0, 0, 0,             1, 32'h0000_0000, 1, iw(11),  32'hFFFF_FFFC, 0);

        reset = 1'b1; imem_ack = 0; imem_rdata = 0; stall = 0; is_branch = 0; branch_pc = 0;
        #12;
        chk_reset("por");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata; stall = vecs[i].stall;
            is_branch = vecs[i].br; branch_pc = vecs[i].bpc;
            #1;
            chk($sformatf("row%0d_req", i),   32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("row%0d_addr", i),  imem_addr,     vecs[i].e_addr);
            chk($sformatf("row%0d_idv", i),   32'(id_valid), 32'(vecs[i].e_idv));
            chk($sformatf("row%0d_instr", i), id_instr,      vecs[i].e_instr);
            chk($sformatf("row%0d_idpc", i),  id_pc,         vecs[i].e_idpc);
`ifdef FETCH_ADDR_CHECK_EN
            chk($sformatf("row%0d_err", i),   32'(fetch_addr_err), 32'(vecs[i].e_err));
`endif
            @(negedge clk);
        end
        imem_ack = 0; stall = 0; is_branch = 0; branch_pc = 0;
        // Reset in the middle of an outstanding request.
        chk("mid_req_before", 32'(imem_req), 32'd1);
        #2 reset = 1'b1;
        #1 chk_reset("mid");
        @(negedge clk);
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        #1 chk("boot_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 0;
        #1;
        chk("late_ack_req",  32'(imem_req), 32'd1);
        chk("late_ack_addr", imem_addr,     32'h0040_0000);
        chk("late_ack_idv",  32'(id_valid), 32'd0);
        @(negedge clk);
        chk("wait_idv", 32'(id_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hB000_0000;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 0;
        #1;
        chk("first_idv",   32'(id_valid), 32'd1);
        chk("first_instr", id_instr,      32'hB000_0000);
        chk("first_idpc",  id_pc,         32'h0040_0000);
        chk("first_addr",  imem_addr,     32'h0040_0004);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
